// File: rtl/id_ex_stage_pkg.sv
// Shared RV32I decode constants for the ID/EX stage: sizes, field positions and opcodes.
// The optional writeback bypass in id_ex_stage is enabled with RV_WB_BYPASS_EN.
package id_ex_stage_pkg;

  localparam int INSTRUCTION_SIZE = 32;
  localparam int REG_COUNT        = 32;

  localparam int OPCODE_LSB   = 0;
  localparam int RD_LSB       = 7;
  localparam int FUNCT3_LSB   = 12;
  localparam int RS1_LSB      = 15;
  localparam int RS2_LSB      = 20;
  localparam int FUNCT7B5_BIT = 30;
  localparam int SIGN_BIT     = 31;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_OPIMM  = 7'b0010011,
    OP_OP     = 7'b0110011
  } opcode_e;

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// Combinational immediate generator: I/S/B/U/J formats, sign-extended from bit 31.
module imm_gen
  import id_ex_stage_pkg::*;
(
  input  logic [INSTRUCTION_SIZE-1:0] instr,
  output logic [INSTRUCTION_SIZE-1:0] imm
);

  opcode_e opcode;
  logic    sign;

  assign opcode = opcode_e'(instr[OPCODE_LSB +: 7]);
  assign sign   = instr[SIGN_BIT];

  always_comb begin
    imm = '0;
    case (opcode)
      OP_OPIMM, OP_LOAD, OP_JALR:
        imm = {{20{sign}}, instr[31:20]};
      OP_STORE:
        imm = {{20{sign}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm = {{19{sign}}, sign, instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {instr[31:12], 12'b0};
      OP_JAL:
        imm = {{11{sign}}, sign, instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode / operand-issue stage with ID/EX pipeline register and load-use stall.
// Define RV_WB_BYPASS_EN to forward writeback data instead of stalling on a same-cycle RF write.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN   = INSTRUCTION_SIZE,
  parameter int REG_AW = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              flush,
  output logic [REG_AW-1:0] rf_rs1,
  output logic [REG_AW-1:0] rf_rs2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall_if,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [6:0]        ex_opcode,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_regwrite,
  output logic              ex_illegal
);

  opcode_e           opcode;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]   imm, op1, op2;
  logic              rs1_used, rs2_used, writes_rd, is_load, is_store, illegal;
  logic              hz_load, hz;

  assign opcode = opcode_e'(id_instr[OPCODE_LSB +: 7]);
  assign rs1    = id_instr[RS1_LSB +: REG_AW];
  assign rs2    = id_instr[RS2_LSB +: REG_AW];
  assign rd     = id_instr[RD_LSB +: REG_AW];
  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;

  imm_gen u_imm_gen (
    .instr (id_instr),
    .imm   (imm)
  );

  always_comb begin
    rs1_used  = 1'b1;
    rs2_used  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        rs1_used  = 1'b0;
        writes_rd = 1'b1;
      end
      OP_JALR, OP_OPIMM: writes_rd = 1'b1;
      OP_LOAD: begin
        writes_rd = 1'b1;
        is_load   = 1'b1;
      end
      OP_STORE: begin
        rs2_used = 1'b1;
        is_store = 1'b1;
      end
      OP_BRANCH: rs2_used = 1'b1;
      OP_OP: begin
        rs2_used  = 1'b1;
        writes_rd = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign hz_load = ex_valid && ex_memread && (ex_rd != '0) && id_valid &&
                   ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));

`ifdef RV_WB_BYPASS_EN
  logic byp1, byp2;
  assign byp1 = wb_regwrite && (wb_rd != '0) && (wb_rd == rs1);
  assign byp2 = wb_regwrite && (wb_rd != '0) && (wb_rd == rs2);
  assign op1  = (rs1 == '0) ? '0 : (byp1 ? wb_data : rf_rdata1);
  assign op2  = (rs2 == '0) ? '0 : (byp2 ? wb_data : rf_rdata2);
  assign hz   = hz_load;
`else
  // Without forwarding, wait one cycle for the register file write to land.
  logic hz_wb;
  logic unused_wb_data;
  assign hz_wb = wb_regwrite && (wb_rd != '0) && id_valid &&
                 ((rs1_used && wb_rd == rs1) || (rs2_used && wb_rd == rs2));
  assign hz    = hz_load || hz_wb;
  assign op1   = (rs1 == '0) ? '0 : rf_rdata1;
  assign op2   = (rs2 == '0) ? '0 : rf_rdata2;
  assign unused_wb_data = ^wb_data;
`endif

  assign stall_if = hz && !flush && !rst;

  // Reset, flush, hazard and empty ID all load the same all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst || flush || hz || !id_valid) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_op1      <= '0;
      ex_op2      <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_illegal  <= 1'b0;
    end else begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_op1      <= op1;
      ex_op2      <= op2;
      ex_imm      <= imm;
      ex_rd       <= rd;
      ex_rs1      <= rs1;
      ex_rs2      <= rs2;
      ex_opcode   <= id_instr[OPCODE_LSB +: 7];
      ex_funct3   <= id_instr[FUNCT3_LSB +: 3];
      ex_funct7b5 <= id_instr[FUNCT7B5_BIT];
      ex_memread  <= is_load;
      ex_memwrite <= is_store;
      ex_regwrite <= writes_rd && (rd != '0);
      ex_illegal  <= illegal;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (builds with or without RV_WB_BYPASS_EN).
module tb_id_ex_stage;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [31:0] I_ADDI  = 32'hFFC08293; // addi x5,x1,-4
  localparam logic [31:0] I_LW    = 32'h00012183; // lw   x3,0(x2)
  localparam logic [31:0] I_ADD   = 32'h00118233; // add  x4,x3,x1
  localparam logic [31:0] I_ADD0  = 32'h000004B3; // add  x9,x0,x0
  localparam logic [31:0] I_ADDI7 = 32'h00038413; // addi x8,x7,0

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [31:0]       id_instr;
  logic [XLEN-1:0]   id_pc;
  logic              flush;
  logic [REG_AW-1:0] rf_rs1, rf_rs2;
  logic [XLEN-1:0]   rf_rdata1, rf_rdata2;
  logic              wb_regwrite;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              stall_if;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_op1, ex_op2, ex_imm;
  logic [REG_AW-1:0] ex_rd, ex_rs1, ex_rs2;
  logic [6:0]        ex_opcode;
  logic [2:0]        ex_funct3;
  logic              ex_funct7b5, ex_memread, ex_memwrite, ex_regwrite, ex_illegal;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .flush(flush), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rdata1(rf_rdata1),
    .rf_rdata2(rf_rdata2), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_if(stall_if), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1),
    .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite),
    .ex_illegal(ex_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; id_valid = 1'b1; id_instr = I_ADDI; flush = 1'b0;
    id_pc = 32'h100; rf_rdata1 = 32'd10; rf_rdata2 = '0;
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
    #1;
    n_checks++; if (stall_if !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_stall: got %b want 0", stall_if); end
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_valid: got %b want 0", ex_valid); end
    n_checks++; if (ex_regwrite !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_regwrite: got %b want 0", ex_regwrite); end
    n_checks++; if (ex_imm !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_imm: got %h want 0", ex_imm); end
    n_checks++; if (stall_if !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_stall_after: got %b want 0", stall_if); end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    id_instr = I_ADDI; id_valid = 1'b1; id_pc = 32'h0000_0200; rf_rdata1 = 32'd10;
    #1;
    n_checks++; if (rf_rs1 !== 5'd1) begin n_fails++; $display("[TB] FAIL addi_rf_rs1: got %0d want 1", rf_rs1); end
    tick();
    n_checks++; if (ex_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL addi_valid: got %b want 1", ex_valid); end
    n_checks++; if (ex_op1 !== 32'd10) begin n_fails++; $display("[TB] FAIL addi_op1: got %h want 0000000a", ex_op1); end
    n_checks++; if (ex_imm !== 32'hFFFFFFFC) begin n_fails++; $display("[TB] FAIL addi_imm: got %h want fffffffc", ex_imm); end
    n_checks++; if (ex_rd !== 5'd5) begin n_fails++; $display("[TB] FAIL addi_rd: got %0d want 5", ex_rd); end
    n_checks++; if (ex_regwrite !== 1'b1) begin n_fails++; $display("[TB] FAIL addi_regwrite: got %b want 1", ex_regwrite); end
    n_checks++; if (ex_pc !== 32'h200) begin n_fails++; $display("[TB] FAIL addi_pc: got %h want 00000200", ex_pc); end
  endtask

  task automatic test_formats();
    // sw x5,-8(x6); beq x1,x2,-16; jal x1,+2048; lui x0,0x12345; opcode 0x7f
    logic [31:0] t_instr [5] = '{32'hFE532C23, 32'hFE2088E3, 32'h001000EF, 32'h12345037, 32'h0000007F};
    logic [31:0] t_imm   [5] = '{32'hFFFFFFF8, 32'hFFFFFFF0, 32'h00000800, 32'h12345000, 32'h00000000};
    logic        t_rw    [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        t_mw    [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        t_ill   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  t_f3    [5] = '{3'd2, 3'd0, 3'd0, 3'd5, 3'd0};
    logic [6:0]  want_op;
    rf_rdata1 = 32'h1111; rf_rdata2 = 32'd99;
    for (int i = 0; i < 5; i++) begin
      id_instr = t_instr[i]; id_valid = 1'b1;
      want_op = t_instr[i][6:0];
      tick();
      n_checks++; if (ex_imm !== t_imm[i]) begin n_fails++; $display("[TB] FAIL fmt%0d_imm: got %h want %h", i, ex_imm, t_imm[i]); end
      n_checks++; if (ex_regwrite !== t_rw[i]) begin n_fails++; $display("[TB] FAIL fmt%0d_regwrite: got %b want %b", i, ex_regwrite, t_rw[i]); end
      n_checks++; if (ex_memwrite !== t_mw[i]) begin n_fails++; $display("[TB] FAIL fmt%0d_memwrite: got %b want %b", i, ex_memwrite, t_mw[i]); end
      n_checks++; if (ex_illegal !== t_ill[i]) begin n_fails++; $display("[TB] FAIL fmt%0d_illegal: got %b want %b", i, ex_illegal, t_ill[i]); end
      n_checks++; if (ex_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL fmt%0d_valid: got %b want 1", i, ex_valid); end
      n_checks++; if (ex_funct3 !== t_f3[i]) begin n_fails++; $display("[TB] FAIL fmt%0d_funct3: got %0d want %0d", i, ex_funct3, t_f3[i]); end
      n_checks++; if (ex_opcode !== want_op) begin n_fails++; $display("[TB] FAIL fmt%0d_opcode: got %h want %h", i, ex_opcode, want_op); end
      if (i == 0) begin
        n_checks++; if (ex_op2 !== 32'd99) begin n_fails++; $display("[TB] FAIL sw_op2: got %h want 00000063", ex_op2); end
      end
    end
  endtask

  task automatic test_x0_operands();
    id_instr = I_ADD0; id_valid = 1'b1; rf_rdata1 = 32'h1234; rf_rdata2 = 32'h5678;
    tick();
    n_checks++; if (ex_op1 !== 32'h0) begin n_fails++; $display("[TB] FAIL x0_op1: got %h want 0", ex_op1); end
    n_checks++; if (ex_op2 !== 32'h0) begin n_fails++; $display("[TB] FAIL x0_op2: got %h want 0", ex_op2); end
    n_checks++; if (ex_regwrite !== 1'b1) begin n_fails++; $display("[TB] FAIL x0_regwrite: got %b want 1", ex_regwrite); end
  endtask

  task automatic test_load_use();
    id_instr = I_LW; id_valid = 1'b1; rf_rdata1 = 32'h40;
    tick();
    n_checks++; if (ex_memread !== 1'b1) begin n_fails++; $display("[TB] FAIL lw_memread: got %b want 1", ex_memread); end
    id_instr = I_ADD; rf_rdata1 = 32'h7; rf_rdata2 = 32'h9;
    #1;
    n_checks++; if (stall_if !== 1'b1) begin n_fails++; $display("[TB] FAIL lu_stall: got %b want 1", stall_if); end
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL lu_bubble: got %b want 0", ex_valid); end
    n_checks++; if (ex_regwrite !== 1'b0) begin n_fails++; $display("[TB] FAIL lu_bubble_rw: got %b want 0", ex_regwrite); end
    n_checks++; if (stall_if !== 1'b0) begin n_fails++; $display("[TB] FAIL lu_stall_release: got %b want 0", stall_if); end
    tick();
    n_checks++; if (ex_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL lu_issue_valid: got %b want 1", ex_valid); end
    n_checks++; if (ex_rs1 !== 5'd3) begin n_fails++; $display("[TB] FAIL lu_issue_rs1: got %0d want 3", ex_rs1); end
    n_checks++; if (ex_rs2 !== 5'd1) begin n_fails++; $display("[TB] FAIL lu_issue_rs2: got %0d want 1", ex_rs2); end
    n_checks++; if (ex_op1 !== 32'h7) begin n_fails++; $display("[TB] FAIL lu_issue_op1: got %h want 7", ex_op1); end
  endtask

  task automatic test_load_use_flush();
    id_instr = I_LW; id_valid = 1'b1;
    tick();
    id_instr = I_ADD; flush = 1'b1;
    #1;
    n_checks++; if (stall_if !== 1'b0) begin n_fails++; $display("[TB] FAIL flush_stall: got %b want 0", stall_if); end
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL flush_bubble: got %b want 0", ex_valid); end
    n_checks++; if (ex_memread !== 1'b0) begin n_fails++; $display("[TB] FAIL flush_memread: got %b want 0", ex_memread); end
    flush = 1'b0; id_valid = 1'b0;
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL flush_no_issue: got %b want 0", ex_valid); end
  endtask

  task automatic test_reset_mid_stall();
    id_instr = I_LW; id_valid = 1'b1;
    tick();
    id_instr = I_ADD;
    #1;
    n_checks++; if (stall_if !== 1'b1) begin n_fails++; $display("[TB] FAIL rms_stall: got %b want 1", stall_if); end
    rst = 1'b1;
    #1;
    n_checks++; if (stall_if !== 1'b0) begin n_fails++; $display("[TB] FAIL rms_stall_drop: got %b want 0", stall_if); end
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_memread !== 1'b0) begin n_fails++; $display("[TB] FAIL rms_cleared: got valid=%b memread=%b want 0/0", ex_valid, ex_memread); end
    rst = 1'b0; id_valid = 1'b0;
    tick();
  endtask

  task automatic test_wb_window();
    id_instr = I_ADDI7; id_valid = 1'b1; rf_rdata1 = 32'h0;
    wb_regwrite = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
    #1;
`ifdef RV_WB_BYPASS_EN
    n_checks++; if (stall_if !== 1'b0) begin n_fails++; $display("[TB] FAIL byp_stall: got %b want 0", stall_if); end
    tick();
    wb_regwrite = 1'b0;
`else
    n_checks++; if (stall_if !== 1'b1) begin n_fails++; $display("[TB] FAIL wb_stall: got %b want 1", stall_if); end
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL wb_bubble: got %b want 0", ex_valid); end
    wb_regwrite = 1'b0; rf_rdata1 = 32'hDEADBEEF;
    #1;
    n_checks++; if (stall_if !== 1'b0) begin n_fails++; $display("[TB] FAIL wb_stall_release: got %b want 0", stall_if); end
    tick();
`endif
    n_checks++; if (ex_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL wb_issue_valid: got %b want 1", ex_valid); end
    n_checks++; if (ex_op1 !== 32'hDEADBEEF) begin n_fails++; $display("[TB] FAIL wb_op1: got %h want deadbeef", ex_op1); end
    n_checks++; if (ex_rd !== 5'd8) begin n_fails++; $display("[TB] FAIL wb_rd: got %0d want 8", ex_rd); end
  endtask

  initial begin
    $display("[TB] id_ex_stage directed test start");
    test_reset();
    test_addi();
    test_formats();
    test_x0_operands();
    test_load_use();
    test_load_use_flush();
    test_reset_mid_stall();
    test_wb_window();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode/operand-issue stage sitting between the register file and the execute stage of the RV32I pipeline.
- Drives rs1/rs2 read addresses into the register file and consumes its combinational read data.
- Generates immediates and control bits, then registers everything into the ID/EX pipeline register.
- Detects load-use hazards, stalling upstream and inserting bubbles; honours branch flushes from EX.

Parameters:
XLEN, 32, datapath width (equals `INSTRUCTION_SIZE)
REG_AW, 5, register address width ($clog2(`REG_COUNT))

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  IF/ID holds a valid instruction
id_instr  in  32  instruction from IF/ID
id_pc  in  XLEN  PC of id_instr
flush  in  1  branch/jump redirect from EX; kill ID content
rf_rs1  out  REG_AW  register-file read address 1 (id_instr[19:15])
rf_rs2  out  REG_AW  register-file read address 2 (id_instr[24:20])
rf_rdata1  in  XLEN  register-file read data 1
rf_rdata2  in  XLEN  register-file read data 2
wb_regwrite  in  1  writeback stage writes this cycle
wb_rd  in  REG_AW  writeback destination
wb_data  in  XLEN  writeback data
stall_if  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX register holds a real instruction
ex_pc  out  XLEN
ex_op1  out  XLEN  rs1 value
ex_op2  out  XLEN  rs2 value
ex_imm  out  XLEN  sign-extended immediate
ex_rd  out  REG_AW
ex_rs1  out  REG_AW  for EX forwarding
ex_rs2  out  REG_AW
ex_opcode  out  7
ex_funct3  out  3
ex_funct7b5  out  1  instr[30]
ex_memread  out  1  load
ex_memwrite  out  1  store
ex_regwrite  out  1  writes rd (forced 0 when rd==0)
ex_illegal  out  1  unrecognised opcode

Behaviour:
- Reset (clk edge with rst=1): every ex_* output is 0; stall_if is combinational and reads 0 during reset.
- Latency: 1 cycle. Fields from id_instr at edge N appear on ex_* after edge N.
- Register use:
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used only by OP, STORE and BRANCH.
- Hazard: hz = ex_valid & ex_memread & ex_rd!=0 & id_valid & ((rs1 used & ex_rd==rs1) | (rs2 used & ex_rd==rs2)).
- stall_if = hz & ~flush.
- Edge update, in priority order:
  - rst
  - flush → bubble
  - hz → bubble, with IF/ID held upstream so the same instruction is re-decoded next cycle
  - ~id_valid → bubble
  - else → load the decoded instruction.
- A bubble loads ex_valid=0, ex_regwrite=0, ex_memread=0, ex_memwrite=0 and ex_illegal=0; other fields are don't-care but held at 0.
- Immediate formats, all sign-extended from instr[31]:
  - I: OPIMM, LOAD, JALR
  - S: STORE
  - B: BRANCH, bit0=0
  - U: LUI, AUIPC, low 12 bits 0
  - J: JAL, bit0=0
  - 0 for OP.
- Control bits:
  - ex_regwrite = valid & rd!=0 & opcode in {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP}.
  - Unknown opcode: ex_valid=1, ex_illegal=1, no regwrite/memread/memwrite.
- Operand rule: for an operand whose address is x0, ex_opN = 0 regardless of rf_rdata or bypass.
- Simultaneous flush + hz: flush wins, stall_if=0.
- Reset mid-stall: pipeline register cleared and stall_if drops in the same cycle.

Optional Feature:
Macro: RV_WB_BYPASS_EN
- Defined:
  - If wb_regwrite & wb_rd!=0 & wb_rd==rf_rs1, then ex_op1 captures wb_data instead of rf_rdata1; rs2 is handled the same way.
  - This covers the register-file write-at-edge / read-combinational window.
- Undefined:
  - No bypass.
  - hz additionally includes (wb_regwrite & wb_rd!=0 & id_valid & a used rs matching wb_rd). This stalls one cycle until the write has landed.

Decomposition:
- RISCV_PKG.vh gains the opcode constants OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM and OP_OP.
- RISCV_PKG.vh also gains the instruction field slice positions; it reuses `INSTRUCTION_SIZE and `REG_COUNT.
- One sub-module, imm_gen: purely combinational, taking the instruction and returning the immediate.

Test Plan:
- Reset with id_valid=1 → ex_valid=0, ex_regwrite=0, ex_imm=0, stall_if=0.
- ADDI x5,x1,-4 (0xFFC08293), rf_rdata1=10 → next cycle ex_op1=10, ex_imm=0xFFFFFFFC, ex_rd=5, ex_regwrite=1.
- LW x3,0(x2), then ADD x4,x3,x1 → stall_if=1 for exactly 1 cycle, one bubble (ex_valid=0), then ADD issued with ex_rs1=3.
- Same load-use pair with flush=1 in the hazard cycle → stall_if=0, bubble loaded, ADD not issued.
- With RV_WB_BYPASS_EN: wb_regwrite=1, wb_rd=7, wb_data=0xDEADBEEF, ID reads x7 (rf_rdata=0) → ex_op1=0xDEADBEEF. Without the macro: 1-cycle stall, then ex_op1=rf_rdata.
- LUI x0,0x12345 → ex_regwrite=0, ex_imm=0x12345000. Opcode 0x7F → ex_illegal=1, ex_valid=1.
